// File: rtl/btn_pkg.sv
// btn_pkg: shared state encodings and debounce defaults for button conditioning
package btn_pkg;
  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] HELD         = 2'b11;
  localparam logic [1:0] RELEASE_WAIT = 2'b10;
  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_BOARD = 500000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_q, s_q;
  always_ff @(posedge clk) begin
    s1_q <= reset ? 1'b0 : d;
    s_q  <= reset ? 1'b0 : s1_q;
  end
  assign q = s_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces a push-button into press/release strobes and a level
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_level,
  output logic [1:0] state_dbg
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d, release_q, release_d, level_q, level_d;
  logic             last;
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s)
  );
  assign last = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  // A pending change needs DEBOUNCE_CYCLES matching samples, counting the one that left the stable state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
    case (state_q)
      IDLE: begin
        state_d = s ? PRESS_WAIT : IDLE;
        cnt_d   = s ? CNT_W'(1) : '0;
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      HELD: begin
        state_d = s ? HELD : RELEASE_WAIT;
        cnt_d   = s ? '0 : CNT_W'(1);
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (last) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_level   = level_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed stimulus with a history-window debounce model checked every cycle
module tb_btn_conditioner;
  localparam int N = 4;
  logic       clk = 1'b0, reset = 1'b1, btn_raw = 1'b0;
  logic       btn_press, btn_release, btn_level;
  logic [1:0] state_dbg;
  int         tests = 0, fails = 0;
  int         press_cnt = 0, rel_cnt = 0, p0, r0;
  logic       last_was_press = 1'b0, light;
  logic       m_s1 = 1'b0, m_s = 1'b0, m_lvl = 1'b0, m_press = 1'b0, m_rel = 1'b0;
  logic [N-1:0] m_hist = '0;
  logic [1:0] m_state;
  logic [7:0] pat;

  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_level   (btn_level),
    .state_dbg   (state_dbg)
  );

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      btn_raw = v;
    end
  endtask

  // Model: accept a new level once the last N synchronized samples all disagree with it
  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 1'b0; m_s = 1'b0; m_lvl = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_hist = '0;
    end else begin
      m_hist  = {m_hist[N-2:0], m_s};
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (m_hist == {N{~m_lvl}}) begin
        m_lvl   = ~m_lvl;
        m_press = m_lvl;
        m_rel   = ~m_lvl;
      end
      m_s  = m_s1;
      m_s1 = btn_raw;
    end
    m_state = m_lvl ? ((m_hist[0] != m_lvl) ? 2'b10 : 2'b11)
                    : ((m_hist[0] != m_lvl) ? 2'b01 : 2'b00);
  end

  always_ff @(posedge clk) light <= reset ? 1'b0 : light ^ btn_press;

  always @(posedge clk) begin
    #1;
    chk("m_press", btn_press, m_press);
    chk("m_release", btn_release, m_rel);
    chk("m_level", btn_level, m_lvl);
    chk("m_state", state_dbg, m_state);
    chk("no_overlap", btn_press & btn_release, 2'b00);
    if (btn_press) begin
      chk("alt_press", last_was_press, 1'b0);
      last_was_press = 1'b1;
      press_cnt++;
    end
    if (btn_release) begin
      chk("alt_release", last_was_press, 1'b1);
      last_was_press = 1'b0;
      rel_cnt++;
    end
    if (reset) last_was_press = 1'b0;
  end

  initial begin
    @(posedge clk); #1;
    chk("rst_press", btn_press, 1'b0);
    chk("rst_release", btn_release, 1'b0);
    chk("rst_level", btn_level, 1'b0);
    chk("rst_state", state_dbg, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    drive(1'b0, 4);
    @(negedge clk) btn_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("clean_press_e%0d", k), btn_press, (k == 5) ? 2'b01 : 2'b00);
    end
    chk("clean_level", btn_level, 1'b1);
    chk("clean_state", state_dbg, 2'b11);
    drive(1'b1, 2);
    drive(1'b0, 10);
    chk("clean_rel_level", btn_level, 1'b0);
    chk("clean_rel_state", state_dbg, 2'b00);
    p0 = press_cnt;
    pat = 8'b1110_1110;
    for (int i = 7; i >= 0; i--) drive(pat[i], 1);
    drive(1'b1, 2);
    chk("bounce_no_press", 2'(press_cnt - p0), 2'd0);
    chk("bounce_level", btn_level, 1'b0);
    drive(1'b1, 4);
    drive(1'b1, 3);
    chk("bounce_one_press", 2'(press_cnt - p0), 2'd1);
    chk("bounce_held_level", btn_level, 1'b1);
    chk("glitch_pre_state", state_dbg, 2'b11);
    r0 = rel_cnt;
    drive(1'b0, 2);
    drive(1'b1, 8);
    chk("glitch_no_release", 2'(rel_cnt - r0), 2'd0);
    chk("glitch_level", btn_level, 1'b1);
    chk("glitch_state", state_dbg, 2'b11);
    drive(1'b0, 6);
    drive(1'b0, 3);
    chk("glitch_one_release", 2'(rel_cnt - r0), 2'd1);
    chk("glitch_rel_level", btn_level, 1'b0);
    chk("glitch_rel_state", state_dbg, 2'b00);
    @(negedge clk) btn_raw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("rmp_state_pw", state_dbg, 2'b01);
    p0 = press_cnt;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rmp_state_idle", state_dbg, 2'b00);
    chk("rmp_no_strobe", {btn_press, btn_release}, 2'b00);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rmp_press_e%0d", k), btn_press, (k == 5) ? 2'b01 : 2'b00);
    end
    chk("rmp_one_press", 2'(press_cnt - p0), 2'd1);
    drive(1'b0, 10);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    p0 = press_cnt;
    r0 = rel_cnt;
    repeat (3) begin
      drive(1'b1, 8);
      drive(1'b0, 8);
    end
    drive(1'b0, 2);
    chk("e2e_presses", 2'(press_cnt - p0), 2'd3);
    chk("e2e_releases", 2'(rel_cnt - r0), 2'd3);
    chk("e2e_light_on", light, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
